decode38_scan: RTL and testbench

- Registered 3-to-8 one-hot decoder with enable. It is the decode-side counterpart of the team's 8-to-3 priority encoder.
- Two modes:
  - DIRECT: external 3-bit codes arrive over a valid/ready handshake and are decoded.
  - SCAN: an internal divider steps the index 0..7 continuously.
- Drives digit-select lines of the 8-digit seven-segment display on the lab board, and any one-hot select bus elsewhere in the lab designs.

---
 rtl/decode_pkg.sv | 23 ++
 rtl/scan_divider.sv | 36 +++
 rtl/decode38_scan.sv | 110 +++++++++++
 tb/tb_decode38_scan.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
//------------------------------------------------------------------------------
// decode_pkg : shared state encoding and one-hot helper for decode38_scan
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package decode_pkg;

   localparam int ONEHOT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   function automatic logic [ONEHOT_W-1:0] onehot3(input logic [2:0] code);
      return ONEHOT_W'(1) << code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/scan_divider.sv
//------------------------------------------------------------------------------
// scan_divider : free-running modulo-SCAN_DIV counter, tick on last count
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module scan_divider #(
   parameter int DIV_W    = 16,
   parameter int SCAN_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] count;

   assign tick = en & (count == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/decode38_scan.sv
//------------------------------------------------------------------------------
// decode38_scan : registered 3-to-8 one-hot decoder, DIRECT handshake or SCAN
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decode38_scan
   import decode_pkg::*;
#(
   parameter int DIV_W          = 16,
   parameter int SCAN_DIV       = 50000,
   parameter int ACTIVE_LOW_OUT = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                mode,
   input  logic                code_valid,
   input  logic [2:0]          code,
   output logic                code_ready,
   output logic [ONEHOT_W-1:0] y,
   output logic [2:0]          idx,
   output logic                y_valid,
   output logic                frame_done
);

   // Polarity mask folded into every y load so the register holds the physical level
   localparam logic [ONEHOT_W-1:0] Y_POL = {ONEHOT_W{ACTIVE_LOW_OUT != 0}};

   state_t state;
   state_t next_state;
   logic   div_clr;
   logic   div_en;
   logic   div_tick;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = IDLE;
      if (en) begin
         next_state = mode ? SCAN : DIRECT;
      end
   end

   always_comb begin
      code_ready = (state == DIRECT) & en & ~mode;
      div_en     = (state == SCAN) & (next_state == SCAN);
      div_clr    = ~div_en;
   end

   scan_divider #(
      .DIV_W    (DIV_W),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan_divider (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (div_clr),
      .en    (div_en),
      .tick  (div_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y          <= Y_POL;
         idx        <= 3'd0;
         y_valid    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (next_state)
            DIRECT: begin
               if (state != DIRECT) begin
                  y       <= Y_POL;
                  idx     <= 3'd0;
                  y_valid <= 1'b0;
               end else if (code_valid && code_ready) begin
                  y       <= onehot3(code) ^ Y_POL;
                  idx     <= code;
                  y_valid <= 1'b1;
               end
            end
            SCAN: begin
               if (state != SCAN) begin
                  y       <= onehot3(3'd0) ^ Y_POL;
                  idx     <= 3'd0;
                  y_valid <= 1'b1;
               end else if (div_tick) begin
                  y          <= onehot3(idx + 3'd1) ^ Y_POL;
                  idx        <= idx + 3'd1;
                  frame_done <= (idx == 3'd7);
               end
            end
            default: begin
               y       <= Y_POL;
               idx     <= 3'd0;
               y_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_decode38_scan.sv
//------------------------------------------------------------------------------
// tb_decode38_scan : scoreboard bench for three decode38_scan configurations
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode38_scan;

   // DUT 0: SCAN_DIV=3, DUT 1: SCAN_DIV=1, DUT 2: SCAN_DIV=1 with active-low y
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic       code_valid;
   logic [2:0] code;

   logic [7:0] y_o   [3];
   logic [2:0] idx_o [3];
   logic       yv_o  [3];
   logic       fd_o  [3];
   logic       rdy_o [3];

   typedef struct {
      int         sel;
      string      name;
      logic [7:0] y;
      logic [2:0] idx;
      logic       yv;
      logic       fd;
      logic       rdy;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   decode38_scan #(.DIV_W(16), .SCAN_DIV(3), .ACTIVE_LOW_OUT(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .code_valid(code_valid),
      .code(code), .code_ready(rdy_o[0]), .y(y_o[0]), .idx(idx_o[0]),
      .y_valid(yv_o[0]), .frame_done(fd_o[0])
   );

   decode38_scan #(.DIV_W(16), .SCAN_DIV(1), .ACTIVE_LOW_OUT(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .code_valid(code_valid),
      .code(code), .code_ready(rdy_o[1]), .y(y_o[1]), .idx(idx_o[1]),
      .y_valid(yv_o[1]), .frame_done(fd_o[1])
   );

   decode38_scan #(.DIV_W(16), .SCAN_DIV(1), .ACTIVE_LOW_OUT(1)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .code_valid(code_valid),
      .code(code), .code_ready(rdy_o[2]), .y(y_o[2]), .idx(idx_o[2]),
      .y_valid(yv_o[2]), .frame_done(fd_o[2])
   );

   // y is given in logical polarity; the active-low instance expects it inverted
   task automatic push(input int sel, input string name, input logic [7:0] y,
                       input logic [2:0] idx, input logic yv, input logic fd,
                       input logic rdy);
      exp_t e;
      e.sel  = sel;
      e.name = name;
      e.y    = (sel == 2) ? ~y : y;
      e.idx  = idx;
      e.yv   = yv;
      e.fd   = fd;
      e.rdy  = rdy;
      q.push_back(e);
   endtask

   task automatic push_all(input string name, input logic [7:0] y, input logic [2:0] idx,
                           input logic yv, input logic fd, input logic rdy);
      for (int s = 0; s < 3; s++) begin
         push(s, name, y, idx, yv, fd, rdy);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         m_e = q.pop_front();
         checks++;
         if (y_o[m_e.sel] !== m_e.y || idx_o[m_e.sel] !== m_e.idx ||
             yv_o[m_e.sel] !== m_e.yv || fd_o[m_e.sel] !== m_e.fd ||
             rdy_o[m_e.sel] !== m_e.rdy) begin
            errors++;
            $display("FAIL %s dut%0d: got y=%h idx=%0d y_valid=%b frame_done=%b code_ready=%b, want y=%h idx=%0d y_valid=%b frame_done=%b code_ready=%b",
                     m_e.name, m_e.sel, y_o[m_e.sel], idx_o[m_e.sel], yv_o[m_e.sel],
                     fd_o[m_e.sel], rdy_o[m_e.sel], m_e.y, m_e.idx, m_e.yv, m_e.fd, m_e.rdy);
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      en         = 1'b1;
      mode       = 1'b1;
      code_valid = 1'b0;
      code       = 3'd0;

      tick(); push_all("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(); push_all("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // n counts edges since SCAN entry; leave SCAN when the fast instances show idx 4
      for (int n = 0; n <= 28; n++) begin
         tick();
         if (n == 28) mode = 1'b0;
         push(0, "scan_div3", 8'h01 << ((n / 3) % 8), 3'((n / 3) % 8), 1'b1, n == 24, 1'b0);
         push(1, "scan_div1", 8'h01 << (n % 8), 3'(n % 8), 1'b1, (n > 0) && (n % 8 == 0), 1'b0);
         push(2, "scan_div1_al", 8'h01 << (n % 8), 3'(n % 8), 1'b1, (n > 0) && (n % 8 == 0), 1'b0);
      end

      tick();
      code_valid = 1'b1;
      code       = 3'd0;
      push_all("direct_entry", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k < 8; k++) begin
         tick();
         code = 3'(k);
         push_all("direct_b2b", 8'h01 << (k - 1), 3'(k - 1), 1'b1, 1'b0, 1'b1);
      end
      tick();
      code_valid = 1'b0;
      push_all("direct_b2b", 8'h80, 3'd7, 1'b1, 1'b0, 1'b1);
      tick(); push_all("direct_hold", 8'h80, 3'd7, 1'b1, 1'b0, 1'b1);

      tick();
      en         = 1'b0;
      code       = 3'd5;
      code_valid = 1'b1;
      push_all("en_drop", 8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
      tick();
      en         = 1'b1;
      code_valid = 1'b0;
      push_all("idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(); push_all("reenable", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
      code       = 3'd2;
      code_valid = 1'b1;
      push_all("reenable_hold", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
      code_valid = 1'b0;
      push_all("code2", 8'h04, 3'd2, 1'b1, 1'b0, 1'b1);
      tick();
      en = 1'b0;
      push_all("code2_hold", 8'h04, 3'd2, 1'b1, 1'b0, 1'b0);
      tick();
      en   = 1'b1;
      mode = 1'b1;
      push_all("idle2", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

      tick(); push_all("scan_entry", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
      tick();
      rst_n = 1'b0;
      push(0, "scan3_hold", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
      push(1, "scan1_step", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0);
      push(2, "scan1_step_al", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0);
      tick(); push_all("reset_mid_scan", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

      tick();
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
